mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk in 1 system clock, all state updates on rising edge; reset in 1 synchronous active-high reset.
REQ-002 The block SHALL use these parameters: ADDR_W, default 11, memory address width; DATA_W, default 16, memory word width; STARVE_LIMIT, default 3, consecutive fetch denials before fetch is forced.
REQ-003 The block SHALL provide the fetch port: if_req in 1 fetch read request; if_addr in ADDR_W fetch address; if_gnt out 1 fetch accepted this cycle; if_rvalid out 1 fetch data valid; if_rdata out DATA_W fetch read data.
REQ-004 The block SHALL provide the data port: d_req in 1 data request; d_we in 1 1=write, 0=read; d_addr in ADDR_W data address; d_wdata in DATA_W write data; d_gnt out 1 data accepted this cycle; d_rvalid out 1 data read valid; d_rdata out DATA_W data read data.
REQ-005 The block SHALL provide the memory side, which connects directly to blockmem16kx1: mem_we out 1 write enable (wea); mem_addr out ADDR_W (addra); mem_din out DATA_W (dina); mem_dout in DATA_W (douta, registered, 1-cycle read latency).

Function
REQ-006 Arbitration SHALL be combinational within the cycle; exactly one or zero grants per cycle; if_gnt and d_gnt SHALL never both be 1.
REQ-007 Default priority: data port wins when d_req=1 and if_req=1.
REQ-008 The starvation counter SHALL count cycles where if_req=1 and if_gnt=0, saturating at STARVE_LIMIT, and clear on any if_gnt or when if_req=0.
REQ-009 When the starvation counter equals STARVE_LIMIT and if_req=1, fetch SHALL win regardless of d_req.
REQ-010 Handshake: a requester SHALL hold req, addr, we, and wdata stable until the cycle its gnt=1; the transfer completes at that clock edge.
REQ-011 The memory outputs SHALL follow the granted port in the same cycle; with no grant: mem_we=0, mem_addr=last driven address (held), mem_din=0.
REQ-012 mem_we SHALL be 1 only when d_gnt=1 and d_we=1; fetch never writes.
REQ-013 Read response latency SHALL be exactly 1 cycle after gnt: the matching rvalid pulses for one cycle, with rdata=mem_dout in that cycle.
REQ-014 Writes SHALL produce no rvalid; d_gnt is the only write acknowledgement.
REQ-015 A response-route register SHALL record the read owner (NONE/FETCH/DATA) at each grant and select which rvalid fires in the following cycle.
REQ-016 Each port's rdata SHALL hold its last returned word until that port's next rvalid; the value is 0 after reset.
REQ-017 Back-to-back grants SHALL be supported: a new grant in the same cycle as a previous read's rvalid gives full throughput of 1 access per cycle.
REQ-018 Read after write to the same address in consecutive grants SHALL return the newly written data.

Reset
REQ-019 While reset=1, the block SHALL drive if_gnt=d_gnt=0, mem_we=0, and suppress both rvalids.
REQ-020 At the first edge with reset=1, the block SHALL clear the starvation counter to 0, the route register to NONE, both rdata hold registers to 0, and the mem_addr hold to 0.
REQ-021 A read granted in the cycle before reset asserts SHALL be dropped: no rvalid after reset.

Structure
REQ-022 Package mem_pkg SHALL hold ADDR_W, DATA_W, STARVE_LIMIT defaults and the route encoding (NONE=2'd0, FETCH=2'd1, DATA=2'd2).
REQ-023 The starvation counter SHALL be one sub-module, arb_starve_ctr (inputs: clk, reset, req, gnt; output: at_limit).
REQ-024 The expected RTL size is 120-400 lines.

Verification
REQ-025 Data write only: d_req=1, d_we=1, d_addr=5, d_wdata=13 -> d_gnt=1 same cycle, mem_we=1, mem_addr=5, mem_din=13, no d_rvalid.
REQ-026 Fetch read after that write: if_req=1, if_addr=5 -> if_gnt=1; next cycle if_rvalid=1, if_rdata=13; if_rdata still 13 two cycles later.
REQ-027 Contention: both requesting every cycle, data reads at addr 0..7 -> d_gnt for 3 cycles, then if_gnt on the 4th, counter clears, pattern repeats.
REQ-028 Back-to-back reads: data addr 1, then fetch addr 2 on consecutive cycles (mem holds 0x0011, 0x0022) -> d_rvalid/0x0011 then if_rvalid/0x0022 on consecutive cycles, never simultaneous.
REQ-029 Reset mid-read: grant fetch read at addr 5, assert reset next cycle -> if_rvalid=0, if_rdata=0, both gnt=0 while reset=1.
REQ-030 Idle: no requests for 10 cycles -> mem_we=0 throughout, mem_addr holds last value, no gnt or rvalid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults and encodings for the memory arbiter.
//   ADDR_W_DEF       default memory address width
//   DATA_W_DEF       default memory word width
//   STARVE_LIMIT_DEF default consecutive fetch denials before fetch is forced
//   route_e          owner of the read response due in the next cycle
package mem_pkg;

    localparam int ADDR_W_DEF       = 11;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        ROUTE_NONE  = 2'd0,
        ROUTE_FETCH = 2'd1,
        ROUTE_DATA  = 2'd2
    } route_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the block memory.
//   fetch port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   memory     : mem_we, mem_addr, mem_din -> mem_dout (registered, 1-cycle latency)
// Modport slave is the arbiter view; master is the requester/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_we, mem_addr, mem_din
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter.
//   clk, reset : clock, synchronous active-high reset
//   req, gnt   : fetch request and fetch grant of the current cycle
//   at_limit   : counter has reached LIMIT; fetch must win this cycle
// Counts denied fetch cycles, saturates at LIMIT, clears on grant or idle.
module arb_starve_ctr
    import mem_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic at_limit
);
    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port block memory.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave (fetch port, data port, memory side)
// Data wins contention unless fetch has been denied STARVE_LIMIT cycles in a
// row. Grants are combinational; read data returns one cycle after grant and
// is steered by a route register to the port that owned the read.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    logic              at_limit;
    logic              fetch_win;
    route_e            route_q;
    route_e            route_d;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] d_hold;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.if_req),
        .gnt      (bus.if_gnt),
        .at_limit (at_limit)
    );

    always_comb begin
        fetch_win    = bus.if_req & (at_limit | ~bus.d_req);
        bus.if_gnt   = fetch_win & ~reset;
        bus.d_gnt    = bus.d_req & ~fetch_win & ~reset;

        bus.mem_we   = bus.d_gnt & bus.d_we;
        bus.mem_din  = '0;
        bus.mem_addr = addr_hold;
        route_d      = ROUTE_NONE;

        if (bus.d_gnt) begin
            bus.mem_addr = bus.d_addr;
            bus.mem_din  = bus.d_wdata;
            if (!bus.d_we) begin
                route_d = ROUTE_DATA;
            end
        end else if (bus.if_gnt) begin
            bus.mem_addr = bus.if_addr;
            route_d      = ROUTE_FETCH;
        end
    end

    // Gating with reset drops a read granted just before reset asserted.
    always_comb begin
        bus.if_rvalid = ~reset & (route_q == ROUTE_FETCH);
        bus.d_rvalid  = ~reset & (route_q == ROUTE_DATA);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_dout : if_hold;
        bus.d_rdata   = bus.d_rvalid  ? bus.mem_dout : d_hold;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            route_q   <= ROUTE_NONE;
            addr_hold <= '0;
            if_hold   <= '0;
            d_hold    <= '0;
        end else begin
            route_q   <= route_d;
            addr_hold <= bus.mem_addr;
            if (bus.if_rvalid) begin
                if_hold <= bus.mem_dout;
            end
            if (bus.d_rvalid) begin
                d_hold <= bus.mem_dout;
            end
        end
    end
endmodule
